fmap_mem_arbiter: RTL and testbench
===================================

// Module: fmap_mem_arbiter
// PURPOSE
//   Shares one single-port feature-map BRAM between the CNN pipeline stages
//   (conv write-back, relu read-modify-write, pool read, dense read).
//   Round-robin grant with optional locked bursts and a fairness cap.
//   Read data returns to its issuer with a one-hot valid tag.
//   Sits between the stage engines and the shared BRAM, below the stage-sequencing FSM.
// PARAMETERS
//   NREQ      4   number of requesters
//   ADDR_W    12  BRAM address width
//   DATA_W    16  BRAM data width (Q-format is opaque here)
//   MAX_BURST 16  max consecutive locked transfers before forced rotation
//   RD_LAT    1   BRAM read latency in cycles (>=1)
// PORTS
//   clk        in   1              clock, rising edge
//   reset      in   1              asynchronous, active-high
//   req        in   NREQ           access request, held with addr/we/wdata until granted
//   lock       in   NREQ           keep grant for a burst while req stays high
//   we         in   NREQ           1=write, 0=read
//   addr       in   NREQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata      in   NREQ*DATA_W    packed write data, same packing
//   gnt        out  NREQ           one-hot (or zero) registered grant
//   rvalid     out  NREQ           one-hot read-data valid, tagged to the issuer
//   rdata      out  DATA_W         read data (mem_rdata passthrough)
//   mem_en     out  1              BRAM enable
//   mem_we     out  1              BRAM write enable
//   mem_addr   out  ADDR_W         BRAM address
//   mem_wdata  out  DATA_W         BRAM write data
//   mem_rdata  in   DATA_W         BRAM read data, RD_LAT cycles after mem_en&~mem_we
//   busy       out  1              |gnt | any read in flight
// BEHAVIOUR
//   - Reset (async): gnt=0, rr pointer=NREQ-1, burst_cnt=0, read tag pipe=0.
//     Hence rvalid=0, mem_en=0, mem_we=0, busy=0.
//     Reset mid-burst or mid-read drops all in-flight tags; no rvalid after release.
//   - Ownership is register own (one-hot); gnt=own.
//   - Transfer happens in any cycle with gnt[i]&req[i]. In that cycle mem_* are driven
//     combinationally from requester i: mem_en=1, mem_we=we[i].
//     Otherwise mem_en=0, mem_we=0, and addr/wdata are don't-care.
//   - Release condition for owner i, evaluated every cycle:
//     (a) ~req[i], i.e. owner withdrew and no transfer is made; or
//     (b) transfer made and ~lock[i]; or
//     (c) transfer made, lock[i], burst_cnt==MAX_BURST-1, and another req pending.
//   - On release, or when own==0: own <= round-robin pick over req, excluding the
//     releasing owner. Search starts at ptr+1 and wraps modulo NREQ.
//     ptr <= index picked. No pick -> own <= 0.
//   - Case (c) with no other request pending: owner keeps the grant and burst_cnt
//     restarts at 0.
//   - Back-to-back handover has no bubble: new gnt is visible the cycle after the
//     last transfer.
//   - burst_cnt: cleared on any ownership change; +1 per transfer while locked.
//   - Read tags: shift register RD_LAT deep of one-hot issuer.
//     rvalid = tag at depth RD_LAT. Writes push a zero tag.
//   - Handshake rule: requester sees gnt[i] and counts each gnt&req cycle as consumed.
//     It may change addr every cycle of a locked burst.
//   - Simultaneous new requests from all requesters are served strictly in rr order
//     from ptr+1.
//   - Arithmetic: burst_cnt width is $clog2(MAX_BURST)+1, saturating never needed.
//     ptr width is $clog2(NREQ).
// STRUCTURE
//   - Shared package cnn_pkg gains REQ_CONV=0, REQ_RELU=1, REQ_POOL=2, REQ_DENSE=3
//     and localparam NREQ_FMAP=4.
//   - One sub-module: arb_rr_pick. Combinational, inputs req mask + ptr,
//     outputs one-hot pick + index + found.
//   - Read tag pipe, own, ptr and burst_cnt live in this module.
// TESTING
//   1. Reset, all req=0 -> gnt=0, mem_en=0, busy=0 for 10 cycles.
//   2. req=4'b1111, lock=0, all reads -> grants 0,1,2,3,0 on consecutive cycles.
//      rvalid one-hot follows each grant by RD_LAT with matching rdata.
//   3. req[2] locked, 40 writes, req[0] raised at cycle 5
//      -> gnt[2] for exactly 16 transfers, then gnt[0], then gnt[2] again.
//   4. Single locked requester 1, 40 reads, no contention -> gnt[1] held all 40 cycles.
//      Exactly 40 rvalid[1] pulses.
//   5. Owner 3 drops req while granted -> no mem_en that cycle, grant passes to the
//      next pending requester next cycle.
//   6. Assert reset during a locked read burst -> gnt=0 and rvalid=0 immediately.
//      After release, first grant goes to requester 0.

Source files
------------

// File: rtl/fmap_mem_arbiter_pkg.sv
// Shared definitions for the feature-map BRAM arbiter: requester ids,
// default geometry and a small width helper.
package fmap_mem_arbiter_pkg;

    // Requester slots on the shared feature-map BRAM
    localparam int REQ_CONV  = 0;
    localparam int REQ_RELU  = 1;
    localparam int REQ_POOL  = 2;
    localparam int REQ_DENSE = 3;
    localparam int NREQ_FMAP = 4;

    // Default BRAM geometry and arbitration limits
    localparam int FMAP_ADDR_W    = 12;
    localparam int FMAP_DATA_W    = 16;
    localparam int FMAP_MAX_BURST = 16;
    localparam int FMAP_RD_LAT    = 1;

    // Width of an index into n requesters; never zero so a single requester still gets a bit
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_mem_arbiter_if.sv
// Requester-side bus of the feature-map arbiter. The stage engines sit on the
// master modport; the arbiter sits on the slave modport.
interface fmap_mem_arbiter_if
    import fmap_mem_arbiter_pkg::*;
#(
    parameter int NREQ   = NREQ_FMAP,
    parameter int ADDR_W = FMAP_ADDR_W,
    parameter int DATA_W = FMAP_DATA_W
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ-1:0]        we;
    logic [NREQ*ADDR_W-1:0] addr;
    logic [NREQ*DATA_W-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [DATA_W-1:0]      rdata;

    modport master (
        output req, lock, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, lock, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: first set bit of mask searching upward
// from ptr+1 and wrapping modulo NREQ.
module arb_rr_pick
    import fmap_mem_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_FMAP,
    parameter int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic [PTR_W-1:0] idx,
    output logic             found
);

    int slot;

    // Walk the requesters in rotation order starting just after ptr
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        slot  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            slot = (int'(ptr) + k) % NREQ;
            if (!found && mask[slot]) begin
                found      = 1'b1;
                pick[slot] = 1'b1;
                idx        = PTR_W'(slot);
            end
        end
    end

endmodule

// File: rtl/fmap_mem_arbiter.sv
// Shares one single-port feature-map BRAM between the CNN stage engines.
// Round-robin ownership with optional locked bursts capped at MAX_BURST
// transfers when someone else is waiting; read data is tagged back to the
// issuer through a RD_LAT-deep one-hot tag pipe.
module fmap_mem_arbiter
    import fmap_mem_arbiter_pkg::*;
#(
    parameter int NREQ      = NREQ_FMAP,
    parameter int ADDR_W    = FMAP_ADDR_W,
    parameter int DATA_W    = FMAP_DATA_W,
    parameter int MAX_BURST = FMAP_MAX_BURST,
    parameter int RD_LAT    = FMAP_RD_LAT
) (
    input  logic              clk,
    input  logic              reset,
    fmap_mem_arbiter_if.slave bus,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int PTR_W = ptr_width(NREQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    logic [NREQ-1:0]  own;
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] burst_cnt;
    logic [NREQ-1:0]  tag_p [RD_LAT];

    logic [PTR_W-1:0] own_idx;
    logic             xfer;
    logic             own_lock;
    logic             own_we;
    logic             others;
    logic             cap_hit;
    logic             handover;
    logic             rearb;
    logic [NREQ-1:0]  pick_mask;
    logic [NREQ-1:0]  pick;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_found;
    logic [NREQ-1:0]  inflight;

    // Index of the current owner, used to steer its address and write data
    always_comb begin
        own_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (own[i]) own_idx = PTR_W'(i);
        end
    end

    assign xfer     = |(own & bus.req);
    assign own_lock = |(own & bus.lock);
    assign own_we   = |(own & bus.we);
    assign others   = |(bus.req & ~own);
    assign cap_hit  = (burst_cnt == CNT_W'(MAX_BURST - 1));

    // Owner gives up: withdrew, finished an unlocked transfer, or hit the cap with a waiter
    assign handover = (|own && !xfer)
                    || (xfer && !own_lock)
                    || (xfer && own_lock && cap_hit && others);
    assign rearb    = handover || (own == '0);

    // The releasing owner is excluded so a waiter always gets the next slot
    assign pick_mask = bus.req & ~own;

    arb_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .mask  (pick_mask),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // BRAM port follows the owner combinationally in its transfer cycle
    assign mem_en    = xfer;
    assign mem_we    = xfer && own_we;
    assign mem_addr  = bus.addr[own_idx*ADDR_W +: ADDR_W];
    assign mem_wdata = bus.wdata[own_idx*DATA_W +: DATA_W];

    // Ownership, rotation pointer and locked-burst counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            own       <= '0;
            ptr       <= PTR_W'(NREQ - 1);
            burst_cnt <= '0;
        end else if (rearb) begin
            own       <= pick;
            burst_cnt <= '0;
            if (pick_found) ptr <= pick_idx;
        end else if (xfer && own_lock) begin
            burst_cnt <= cap_hit ? '0 : burst_cnt + 1'b1;
        end
    end

    // Read tag pipe: one-hot issuer enters on a read, zero on a write or idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) tag_p[k] <= '0;
        end else begin
            tag_p[0] <= (xfer && !own_we) ? own : '0;
            for (int k = 1; k < RD_LAT; k++) tag_p[k] <= tag_p[k-1];
        end
    end

    // Busy while anyone owns the port or a read is still travelling
    always_comb begin
        inflight = '0;
        for (int k = 0; k < RD_LAT; k++) inflight = inflight | tag_p[k];
        busy = (|own) || (|inflight);
    end

    assign bus.gnt    = own;
    assign bus.rvalid = tag_p[RD_LAT-1];
    assign bus.rdata  = mem_rdata;

endmodule

// File: tb/tb_fmap_mem_arbiter.sv
// Directed bench for fmap_mem_arbiter with a behavioural 1-cycle BRAM.
module tb_fmap_mem_arbiter;
    import fmap_mem_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    fmap_mem_arbiter_if #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    fmap_mem_arbiter #(
        .NREQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .RD_LAT(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Unwritten locations read back a fixed pattern of their address
    function automatic logic [15:0] mval(input int a);
        return 16'h5A00 ^ a[15:0];
    endfunction

    logic [DW-1:0] bram    [4096];
    logic          written [4096];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < 4096; a++) written[a] <= 1'b0;
        end else if (mem_en) begin
            if (mem_we) begin
                bram[mem_addr]    <= mem_wdata;
                written[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr] ? bram[mem_addr] : mval(int'(mem_addr));
            end
        end
    end

    function automatic logic [15:0] peek(input int a);
        return written[a] ? bram[a] : mval(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic r, input logic l, input logic w,
                           input int a, input int d);
        bus.req[i]            = r;
        bus.lock[i]           = l;
        bus.we[i]             = w;
        bus.addr[i*AW +: AW]  = a[AW-1:0];
        bus.wdata[i*DW +: DW] = d[DW-1:0];
    endtask

    int eg [6] = '{0, 1, 2, 4, 8, 1};
    int er [6] = '{0, 0, 1, 2, 4, 8};
    int who  [$];
    int when [$];
    logic [15:0] rq [$];

    initial begin
        logic x0, x1, x2, r0_up;
        int n1, n2, g1, rv1, first1, last1, k, run1, run2, next_owner, gap1, gap2;
        logic [31:0] exp_rd;

        reset     = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;

        // ---- 1: reset and idle
        step();
        #1;
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_busy", busy, 0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            #1;
            chk("idle_gnt", bus.gnt, 0);
            chk("idle_mem_en", mem_en, 0);
            chk("idle_busy", busy, 0);
        end

        // ---- 2: all four request unlocked reads
        step();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 16 + i, 0);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) step();
            #1;
            chk("rr_gnt", bus.gnt, eg[c]);
            chk("rr_rvalid", bus.rvalid, er[c]);
            if (eg[c] != 0) chk("rr_mem_addr", mem_addr, 16 + $clog2(eg[c]));
            if (er[c] != 0) chk("rr_rdata", bus.rdata, mval(16 + $clog2(er[c])));
        end
        step();
        bus.req = '0;
        #1;
        chk("rr_last_rvalid", bus.rvalid, 1);
        chk("rr_last_rdata", bus.rdata, mval(16));
        step();
        step();
        #1;
        chk("rr_end_busy", busy, 0);

        // ---- 3: requester 2 locked 40 writes, requester 0 joins after 5
        set_req(REQ_POOL, 1'b1, 1'b1, 1'b1, 32'h800, 32'hC000);
        x0 = 0; x2 = 0; r0_up = 0; n2 = 0;
        for (int c = 0; c < 120; c++) begin
            step();
            if (x2) begin
                n2++;
                if (n2 == 40) set_req(REQ_POOL, 1'b0, 1'b0, 1'b0, 0, 0);
                else set_req(REQ_POOL, 1'b1, 1'b1, 1'b1, 32'h800 + n2, 32'hC000 + n2);
            end
            if (x0) bus.req[REQ_CONV] = 1'b0;
            if (n2 >= 5 && !r0_up) begin
                r0_up = 1;
                set_req(REQ_CONV, 1'b1, 1'b0, 1'b1, 32'h8F0, 32'hBEEF);
            end
            #1;
            x2 = bus.gnt[REQ_POOL] & bus.req[REQ_POOL];
            x0 = bus.gnt[REQ_CONV] & bus.req[REQ_CONV];
            if (x2) begin who.push_back(2); when.push_back(c); end
            if (x0) begin who.push_back(0); when.push_back(c); end
        end
        k = 0; run1 = 0; run2 = 0; next_owner = -1; gap1 = -1; gap2 = -1;
        while (k < who.size() && who[k] == 2) begin run1++; k++; end
        if (k < who.size()) begin
            next_owner = who[k];
            if (k > 0) gap1 = when[k] - when[k-1];
            k++;
            if (k < who.size()) gap2 = when[k] - when[k-1];
            while (k < who.size() && who[k] == 2) begin run2++; k++; end
        end
        chk("burst_total_xfers", who.size(), 41);
        chk("burst_first_run", run1, 16);
        chk("burst_next_owner", next_owner, 0);
        chk("burst_handover_gap", gap1, 1);
        chk("burst_return_gap", gap2, 1);
        chk("burst_second_run", run2, 24);
        chk("burst_mem_first", peek(32'h800), 16'hC000);
        chk("burst_mem_cap", peek(32'h80F), 16'hC00F);
        chk("burst_mem_last", peek(32'h827), 16'hC027);
        chk("burst_mem_req0", peek(32'h8F0), 16'hBEEF);

        // ---- 4: single locked reader, 40 reads
        step();
        set_req(REQ_RELU, 1'b1, 1'b1, 1'b0, 32'h100, 0);
        x1 = 0; n1 = 0; g1 = 0; rv1 = 0; first1 = -1; last1 = -1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (x1) begin
                n1++;
                if (n1 == 40) set_req(REQ_RELU, 1'b0, 1'b0, 1'b0, 0, 0);
                else bus.addr[REQ_RELU*AW +: AW] = AW'(32'h100 + n1);
            end
            #1;
            x1 = bus.gnt[REQ_RELU] & bus.req[REQ_RELU];
            if (x1) begin
                g1++;
                if (first1 < 0) first1 = c;
                last1 = c;
                rq.push_back(mval(256 + n1));
            end
            chk("lock_rvalid_tag", bus.rvalid & 4'b1101, 0);
            if (bus.rvalid[REQ_RELU]) begin
                rv1++;
                exp_rd = (rq.size() > 0) ? {16'h0, rq.pop_front()} : 32'hFFFF_FFFF;
                chk("lock_rdata", bus.rdata, exp_rd);
            end
        end
        chk("lock_gnt_cycles", g1, 40);
        chk("lock_gnt_span", last1 - first1 + 1, 40);
        chk("lock_rvalid_count", rv1, 40);

        // ---- 5: owner 3 withdraws while granted, requester 1 waiting
        step();
        set_req(REQ_DENSE, 1'b1, 1'b1, 1'b0, 32'h300, 0);
        #1;
        chk("drop_gnt0", bus.gnt, 0);
        step();
        #1;
        chk("drop_gnt3", bus.gnt, 8);
        chk("drop_en3", mem_en, 1);
        step();
        set_req(REQ_RELU, 1'b1, 1'b0, 1'b0, 32'h123, 0);
        #1;
        chk("drop_gnt3_held", bus.gnt, 8);
        step();
        bus.req[REQ_DENSE] = 1'b0;
        #1;
        chk("drop_gnt3_idle", bus.gnt, 8);
        chk("drop_no_mem_en", mem_en, 0);
        step();
        #1;
        chk("drop_gnt1", bus.gnt, 2);
        chk("drop_en1", mem_en, 1);
        chk("drop_addr1", mem_addr, 32'h123);
        step();
        bus.req[REQ_RELU] = 1'b0;
        #1;
        chk("drop_rvalid1", bus.rvalid, 2);
        chk("drop_rdata1", bus.rdata, mval(32'h123));
        chk("drop_gnt_none", bus.gnt, 0);

        // ---- 6: reset in the middle of a locked read burst
        step();
        set_req(REQ_RELU, 1'b1, 1'b1, 1'b0, 32'h200, 0);
        step();
        step();
        #1;
        chk("mid_rvalid_before", bus.rvalid, 2);
        chk("mid_gnt_before", bus.gnt, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", bus.gnt, 0);
        chk("mid_rst_rvalid", bus.rvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mem_en", mem_en, 0);
        step();
        set_req(REQ_CONV, 1'b1, 1'b0, 1'b0, 32'h210, 0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_gnt", bus.gnt, 0);
        chk("post_rst_rvalid", bus.rvalid, 0);
        step();
        #1;
        chk("post_rst_first_gnt", bus.gnt, 1);
        chk("post_rst_rvalid2", bus.rvalid, 0);
        chk("post_rst_addr", mem_addr, 32'h210);
        step();
        bus.req  = '0;
        bus.lock = '0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
